// File: rtl/noc_pkg.sv
// Shared router constants, lock-state encoding and the packed-port slicing helper.
package noc_pkg;
  localparam int IN_PORTS_DEF      = 5;
  localparam int OUT_PORT_BITS_DEF = 3;
  localparam int PORT_VEC_MAX      = 64;

  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_PKT  = 1'b1
  } lock_e;

  // Field idx of a packed vector of bits-wide fields; caller zero-extends to PORT_VEC_MAX.
  function automatic logic [7:0] port_at(input logic [PORT_VEC_MAX-1:0] vec,
                                         input int idx, input int bits);
    logic [PORT_VEC_MAX-1:0] sh;
    sh = vec >> (idx * bits);
    return sh[7:0] & 8'((1 << bits) - 1);
  endfunction
endpackage

// File: rtl/wormhole_switch_allocator_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    int p;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    p      = 0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr) + k;
      if (p >= N) p = p - N;
      if (!valid && req[p]) begin
        valid     = 1'b1;
        idx       = W'(p);
        onehot[p] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wormhole_switch_allocator.sv
// Per-output switch allocator: round-robin among candidates, then locked to the
// winner from head flit until its tail flit transfers.
module wormhole_switch_allocator
  import noc_pkg::*;
#(
  parameter int IN_PORTS      = IN_PORTS_DEF,
  parameter int OUT_PORT_BITS = OUT_PORT_BITS_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [IN_PORTS-1:0]               requests,
  input  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports,
  input  logic [IN_PORTS-1:0]               req_tail,
  input  logic [IN_PORTS-1:0]               out_ready,
  output logic [IN_PORTS-1:0]               grants,
  output logic [IN_PORTS*OUT_PORT_BITS-1:0] xbar_sel,
  output logic [IN_PORTS-1:0]               xbar_valid,
  output logic [IN_PORTS-1:0]               out_locked,
  output logic                              port_err
);
  logic [PORT_VEC_MAX-1:0]                      req_ports_ext;
  logic [IN_PORTS-1:0][OUT_PORT_BITS-1:0]       req_port;
  logic [IN_PORTS-1:0]                          bad;
  logic [IN_PORTS-1:0][IN_PORTS-1:0]            cand;
  logic [IN_PORTS-1:0][IN_PORTS-1:0]            rr_oh, win_oh;
  logic [IN_PORTS-1:0][OUT_PORT_BITS-1:0]       rr_idx, win_idx;
  logic [IN_PORTS-1:0]                          rr_vld, win_vld, owner_hit, xv, tail_w;
  lock_e [IN_PORTS-1:0]                         lock_q;
  logic [IN_PORTS-1:0][OUT_PORT_BITS-1:0]       owner_q, ptr_q;
  logic [IN_PORTS-1:0]                          g;

  assign req_ports_ext = PORT_VEC_MAX'(req_ports);

  genvar gi, go;
  generate
    for (gi = 0; gi < IN_PORTS; gi++) begin : g_in
      assign req_port[gi] = OUT_PORT_BITS'(port_at(req_ports_ext, gi, OUT_PORT_BITS));
      assign bad[gi]      = requests[gi] & (int'(req_port[gi]) >= IN_PORTS);
    end

    for (go = 0; go < IN_PORTS; go++) begin : g_out
      for (gi = 0; gi < IN_PORTS; gi++) begin : g_cand
        assign cand[go][gi] = requests[gi] & ~bad[gi] &
                              (req_port[gi] == OUT_PORT_BITS'(go));
      end

      rr_pick #(.N(IN_PORTS), .W(OUT_PORT_BITS)) u_pick (
        .req    (cand[go]),
        .ptr    (ptr_q[go]),
        .onehot (rr_oh[go]),
        .idx    (rr_idx[go]),
        .valid  (rr_vld[go])
      );

      // A locked output only ever serves its owner; anyone else waits for the tail.
      assign owner_hit[go] = cand[go][owner_q[go]];
      assign win_vld[go]   = (lock_q[go] == LK_PKT) ? owner_hit[go] : rr_vld[go];
      assign win_idx[go]   = (lock_q[go] == LK_PKT) ? owner_q[go]   : rr_idx[go];
      assign win_oh[go]    = (lock_q[go] == LK_PKT)
                             ? (owner_hit[go] ? (IN_PORTS'(1) << owner_q[go]) : '0)
                             : rr_oh[go];
      assign xv[go]        = win_vld[go] & out_ready[go];
      assign tail_w[go]    = req_tail[win_idx[go]];

      assign xbar_valid[go] = reset & xv[go];
      assign xbar_sel[(go+1)*OUT_PORT_BITS-1 -: OUT_PORT_BITS] =
        (reset && win_vld[go]) ? win_idx[go] : '0;
      assign out_locked[go] = (lock_q[go] == LK_PKT);
    end
  endgenerate

  always_comb begin
    g = '0;
    for (int o = 0; o < IN_PORTS; o++)
      if (xv[o]) g = g | win_oh[o];
  end
  assign grants = reset ? g : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q   <= {IN_PORTS{LK_IDLE}};
      owner_q  <= '0;
      ptr_q    <= '0;
      port_err <= 1'b0;
    end else begin
      for (int o = 0; o < IN_PORTS; o++) begin
        if (xv[o]) begin
          if (tail_w[o]) begin
            lock_q[o] <= LK_IDLE;
            ptr_q[o]  <= (win_idx[o] == OUT_PORT_BITS'(IN_PORTS - 1))
                         ? '0 : win_idx[o] + OUT_PORT_BITS'(1);
          end else if (lock_q[o] == LK_IDLE) begin
            lock_q[o]  <= LK_PKT;
            owner_q[o] <= win_idx[o];
          end
        end
      end
      if (|bad) port_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Directed plus randomized bench for wormhole_switch_allocator against a per-output reference model.
module tb_wormhole_switch_allocator;
  localparam int N = 5;
  localparam int B = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   requests, req_tail, out_ready;
  logic [N*B-1:0] req_ports;
  logic [N-1:0]   grants, xbar_valid, out_locked;
  logic [N*B-1:0] xbar_sel;
  logic           port_err;

  wormhole_switch_allocator #(.IN_PORTS(N), .OUT_PORT_BITS(B)) dut (
    .clk(clk), .reset(reset), .requests(requests), .req_ports(req_ports),
    .req_tail(req_tail), .out_ready(out_ready), .grants(grants),
    .xbar_sel(xbar_sel), .xbar_valid(xbar_valid), .out_locked(out_locked),
    .port_err(port_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_lock[N], m_owner[N], m_ptr[N];
  bit m_err;
  logic [N-1:0]   last_g, last_l;
  logic [N*B-1:0] last_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dst(input int i);
    return int'((req_ports >> (i * B)) & 15'h7);
  endfunction

  task automatic set_req(input int i, input int o, input bit tail);
    requests[i]        = 1'b1;
    req_ports[i*B +: B] = B'(o);
    req_tail[i]        = tail;
  endtask

  // One clock: check combinational outputs at negedge against the model, then advance the model.
  task automatic run_cycle();
    int win[N];
    logic [N-1:0]   eg, ev, el;
    logic [N*B-1:0] es;
    @(negedge clk);
    eg = '0; ev = '0; el = '0; es = '0;
    for (int o = 0; o < N; o++) begin
      win[o] = -1;
      if (m_lock[o] != 0) begin
        if (requests[m_owner[o]] && dst(m_owner[o]) == o) win[o] = m_owner[o];
      end else begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr[o] + k) % N;
          if (win[o] < 0 && requests[i] && dst(i) == o) win[o] = i;
        end
      end
      ev[o] = (win[o] >= 0) && out_ready[o];
      if (win[o] >= 0) es[o*B +: B] = B'(win[o]);
      el[o] = (m_lock[o] != 0);
    end
    for (int i = 0; i < N; i++)
      if (requests[i] && dst(i) < N && ev[dst(i)] && win[dst(i)] == i) eg[i] = 1'b1;
    chk("grants", 32'(grants), 32'(eg));
    chk("xbar_valid", 32'(xbar_valid), 32'(ev));
    chk("xbar_sel", 32'(xbar_sel), 32'(es));
    chk("out_locked", 32'(out_locked), 32'(el));
    chk("port_err", 32'(port_err), 32'(m_err));
    last_g = grants; last_l = out_locked; last_s = xbar_sel;
    @(posedge clk);
    for (int o = 0; o < N; o++) begin
      if (ev[o]) begin
        if (req_tail[win[o]]) begin
          m_lock[o] = 0;
          m_ptr[o]  = (win[o] + 1) % N;
        end else if (m_lock[o] == 0) begin
          m_lock[o]  = 1;
          m_owner[o] = win[o];
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (requests[i] && dst(i) >= N) m_err = 1'b1;
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grants"}, 32'(grants), 32'd0);
    chk({tag, "_xvalid"}, 32'(xbar_valid), 32'd0);
    chk({tag, "_xsel"}, 32'(xbar_sel), 32'd0);
    chk({tag, "_locked"}, 32'(out_locked), 32'd0);
    chk({tag, "_perr"}, 32'(port_err), 32'd0);
  endtask

  task automatic do_reset();
    requests = '0; req_tail = '0; req_ports = '0;
    reset = 1'b0;
    #1;
    check_zero("reset");
    for (int o = 0; o < N; o++) begin
      m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
    end
    m_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order[6];
    order = '{0, 1, 3, 0, 1, 3};
    requests = '0; req_tail = '0; req_ports = '0; out_ready = '1; reset = 1'b1;
    #2;

    // Reset and idle
    do_reset();
    run_cycle();
    chk("idle_grants", 32'(last_g), 32'd0);

    // Round-robin fairness on output 2
    do_reset();
    set_req(0, 2, 1'b1); set_req(1, 2, 1'b1); set_req(3, 2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      run_cycle();
      chk("rr_order", 32'(last_g), 32'(1) << order[c]);
    end

    // Wormhole lock: input 1 four flits to output 4, input 2 competing
    do_reset();
    set_req(1, 4, 1'b0); set_req(2, 4, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) req_tail[1] = 1'b1;
      if (c == 5) requests[1] = 1'b0;
      run_cycle();
      chk("wh_grant", 32'(last_g), (c <= 4) ? 32'h02 : 32'h04);
      chk("wh_lock4", 32'(last_l[4]), (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
    end

    // Backpressure on the 2nd flit
    do_reset();
    set_req(1, 4, 1'b0); set_req(2, 4, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      out_ready[4] = (c != 2);
      if (c == 5) req_tail[1] = 1'b1;
      if (c == 6) requests[1] = 1'b0;
      run_cycle();
      chk("bp_grant", 32'(last_g), (c == 2) ? 32'h00 : (c == 6) ? 32'h04 : 32'h02);
      chk("bp_lock4", 32'(last_l[4]), (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
    end
    out_ready = '1;

    // Reset asserted mid-packet drops everything
    do_reset();
    set_req(1, 4, 1'b0); set_req(2, 4, 1'b1);
    run_cycle();
    run_cycle();
    chk("mid_locked_before", 32'(out_locked[4]), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_zero("midrst");
    do_reset();

    // Parallel outputs
    set_req(0, 1, 1'b1); set_req(1, 0, 1'b1); set_req(2, 3, 1'b1); set_req(3, 2, 1'b1);
    run_cycle();
    chk("par_grants", 32'(last_g), 32'h0F);
    chk("par_sel", 32'(last_s), 32'(15'b000_010_011_000_001));

    // Bad destination port
    do_reset();
    set_req(4, 6, 1'b1);
    run_cycle();
    chk("bad_grant", 32'(last_g[4]), 32'd0);
    chk("bad_err", 32'(port_err), 32'd1);
    requests = '0;
    run_cycle();
    run_cycle();
    chk("bad_err_sticky", 32'(port_err), 32'd1);
    do_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      for (int i = 0; i < N; i++) begin
        requests[i] = ($urandom_range(0, 3) != 0);
        req_ports[i*B +: B] = ($urandom_range(0, 19) == 0) ? B'($urandom_range(5, 7))
                                                             : B'($urandom_range(0, 4));
        req_tail[i]  = ($urandom_range(0, 2) == 0);
        out_ready[i] = ($urandom_range(0, 4) != 0);
      end
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
